// File: rtl/pit_pkg.sv
// Shared encodings for the 8254-style timer host interface: register address,
// read/write access modes and control-word field positions.
package pit_pkg;

   localparam logic [1:0] ADDR_CW  = 2'd3;

   localparam logic [1:0] RW_LATCH = 2'b00;
   localparam logic [1:0] RW_LSB   = 2'b01;
   localparam logic [1:0] RW_MSB   = 2'b10;
   localparam logic [1:0] RW_LM    = 2'b11;

   localparam int CW_SC_HI = 7;
   localparam int CW_SC_LO = 6;
   localparam int CW_RW_HI = 5;
   localparam int CW_RW_LO = 4;
   localparam int CW_M_HI  = 3;
   localparam int CW_M_LO  = 1;

   localparam logic [2:0] MODE_MAX = 3'd2;

   typedef enum logic {
      PTR_LSB = 1'b0,
      PTR_MSB = 1'b1
   } ptr_e;

   // BCD is not supported downstream, so the forwarded word always carries 0.
   function automatic logic [5:0] cw_pack(input logic [1:0] rw, input logic [2:0] mode);
      return {rw, mode, 1'b0};
   endfunction

endpackage

// File: rtl/pit_cnt_port.sv
// Per-counter host port: control word, shared byte pointer, partial LSB,
// count latch and read byte selection.
//   state   | meaning
//   PTR_LSB | next read/write byte is the low byte
//   PTR_MSB | next read/write byte is the high byte (LM mode only)
module pit_cnt_port
   import pit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cw_wr_i,
   input  logic [5:0]  cw_i,
   input  logic        latch_cmd_i,
   input  logic        cnt_wr_i,
   input  logic [7:0]  wr_data_i,
   input  logic        rd_done_i,
   input  logic [15:0] cnt_cur_i,
   output logic [5:0]  ctrl_word_o,
   output logic [7:0]  rd_byte_o,
   output logic        load_o,
   output logic [15:0] load_value_o
);

   logic [5:0]  cw_q;
   ptr_e        ptr_q;
   logic [7:0]  lsb_q;
   logic [15:0] latch_q;
   logic        full_q;
   logic [1:0]  rw;
   logic [15:0] src;

   assign rw          = cw_q[5:4];
   assign ctrl_word_o = cw_q;
   assign src         = full_q ? latch_q : cnt_cur_i;

   always_comb begin
      rd_byte_o = 8'h00;
      case (rw)
         RW_LSB:  rd_byte_o = src[7:0];
         RW_MSB:  rd_byte_o = src[15:8];
         RW_LM:   rd_byte_o = (ptr_q == PTR_MSB) ? src[15:8] : src[7:0];
         default: rd_byte_o = 8'h00;
      endcase
   end

   always_comb begin
      load_o       = 1'b0;
      load_value_o = {wr_data_i, lsb_q};
      case (rw)
         RW_LSB: begin
            load_o       = cnt_wr_i;
            load_value_o = {8'h00, wr_data_i};
         end
         RW_MSB: begin
            load_o       = cnt_wr_i;
            load_value_o = {wr_data_i, 8'h00};
         end
         RW_LM:   load_o = cnt_wr_i && (ptr_q == PTR_MSB);
         default: load_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cw_q    <= '0;
         ptr_q   <= PTR_LSB;
         lsb_q   <= '0;
         latch_q <= '0;
         full_q  <= 1'b0;
      end else if (cw_wr_i) begin
         cw_q   <= cw_i;
         ptr_q  <= PTR_LSB;
         full_q <= 1'b0;
      end else begin
         // A second latch command while full keeps the first snapshot.
         if (latch_cmd_i && !full_q) begin
            latch_q <= cnt_cur_i;
            full_q  <= 1'b1;
         end
         if (cnt_wr_i && rw == RW_LM) begin
            if (ptr_q == PTR_LSB) begin
               lsb_q <= wr_data_i;
               ptr_q <= PTR_MSB;
            end else begin
               ptr_q <= PTR_LSB;
            end
         end
         if (rd_done_i) begin
            case (rw)
               RW_LM: begin
                  ptr_q <= (ptr_q == PTR_LSB) ? PTR_MSB : PTR_LSB;
                  if (ptr_q == PTR_MSB) full_q <= 1'b0;
               end
               RW_LSB, RW_MSB: full_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/pit_bus_ctrl.sv
// Host bus buffer and read/write logic for the timer: samples the bus, decodes
// writes/reads on strobe rising edges and fans commands out to counter ports.
module pit_bus_ctrl
   import pit_pkg::*;
#(
   parameter int N_CNT = 3,
   parameter int CW_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs_n,
   input  logic                  rd_n,
   input  logic                  wr_n,
   input  logic [1:0]            addr,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   output logic                  data_oe,
   output logic [N_CNT*CW_W-1:0] ctrl_word,
   output logic [N_CNT-1:0]      cnt_load,
   output logic [15:0]           cnt_value,
   input  logic [N_CNT*16-1:0]   cnt_current,
   output logic                  bus_err
);

   logic        cs_n_q, rd_n_q, wr_n_q;
   logic [1:0]  addr_q;
   logic [7:0]  data_q;
   logic        clash_q;
   logic [7:0]  data_out_q;
   logic        data_oe_q;
   logic [N_CNT-1:0] cnt_load_q;
   logic [15:0] cnt_value_q;
   logic        bus_err_q;

   logic        sel, clash_now, blocked;
   logic        wr_commit, rd_done, rd_active;
   logic        cw_commit, cw_valid, cw_illegal, cw_prog, latch_cmd;
   logic [1:0]  sc, rw;
   logic [2:0]  mode;
   logic        cnt_wr;

   logic [N_CNT-1:0] port_load;
   logic [15:0]      port_val [N_CNT];
   logic [7:0]       rd_byte  [N_CNT];
   logic [7:0]       rd_sel;
   logic [15:0]      load_val;

   assign sc   = data_q[CW_SC_HI:CW_SC_LO];
   assign rw   = data_q[CW_RW_HI:CW_RW_LO];
   assign mode = data_q[CW_M_HI:CW_M_LO];

   // A write or read overlapped by the other strobe is void until both release.
   assign sel        = !cs_n_q;
   assign clash_now  = sel && !rd_n_q && !wr_n_q;
   assign blocked    = clash_now || clash_q;
   assign wr_commit  = sel && !wr_n_q && wr_n && !blocked;
   assign rd_done    = sel && !rd_n_q && rd_n && !blocked && (addr_q != ADDR_CW);
   assign rd_active  = sel && !rd_n_q && wr_n_q && !clash_q;

   assign cw_commit  = wr_commit && (addr_q == ADDR_CW);
   assign cnt_wr     = wr_commit && (addr_q != ADDR_CW);
   assign cw_valid   = cw_commit && (sc != 2'd3);
   assign cw_illegal = cw_valid && (mode > MODE_MAX);
   assign cw_prog    = cw_valid && !cw_illegal && (rw != RW_LATCH);
   assign latch_cmd  = cw_valid && !cw_illegal && (rw == RW_LATCH);

   for (genvar g = 0; g < N_CNT; g++) begin : g_port
      pit_cnt_port u_port (
         .clk          (clk),
         .rst_n        (rst_n),
         .cw_wr_i      (cw_prog && (sc == 2'(g))),
         .cw_i         (cw_pack(rw, mode)),
         .latch_cmd_i  (latch_cmd && (sc == 2'(g))),
         .cnt_wr_i     (cnt_wr && (addr_q == 2'(g))),
         .wr_data_i    (data_q),
         .rd_done_i    (rd_done && (addr_q == 2'(g))),
         .cnt_cur_i    (cnt_current[g*16 +: 16]),
         .ctrl_word_o  (ctrl_word[g*CW_W +: CW_W]),
         .rd_byte_o    (rd_byte[g]),
         .load_o       (port_load[g]),
         .load_value_o (port_val[g])
      );
   end

   always_comb begin
      rd_sel   = 8'h00;
      load_val = 16'h0000;
      for (int i = 0; i < N_CNT; i++) begin
         if (addr_q == 2'(i)) rd_sel = rd_byte[i];
         if (port_load[i])    load_val = port_val[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         addr_q      <= '0;
         data_q      <= '0;
         clash_q     <= 1'b0;
         data_out_q  <= '0;
         data_oe_q   <= 1'b0;
         cnt_load_q  <= '0;
         cnt_value_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         cs_n_q  <= cs_n;
         rd_n_q  <= rd_n;
         wr_n_q  <= wr_n;
         addr_q  <= addr;
         data_q  <= data_in;
         if (clash_now)           clash_q <= 1'b1;
         else if (rd_n_q && wr_n_q) clash_q <= 1'b0;
         data_oe_q  <= rd_active;
         data_out_q <= !rd_active ? 8'h00 : (addr_q == ADDR_CW) ? 8'hFF : rd_sel;
         cnt_load_q <= port_load;
         if (|port_load) cnt_value_q <= load_val;
         bus_err_q  <= bus_err_q || clash_now || cw_illegal;
      end
   end

   assign data_out  = data_out_q;
   assign data_oe   = data_oe_q;
   assign cnt_load  = cnt_load_q;
   assign cnt_value = cnt_value_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_pit_bus_ctrl.sv
// Directed bench for pit_bus_ctrl: bus writes/reads with hand-computed expectations.
module tb_pit_bus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_n, rd_n, wr_n;
   logic [1:0]  addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [17:0] ctrl_word;
   logic [2:0]  cnt_load;
   logic [15:0] cnt_value;
   logic [47:0] cnt_current;
   logic        bus_err;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rb;
   logic       roe;

   pit_bus_ctrl #(.N_CNT(3), .CW_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cs_n        (cs_n),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .addr        (addr),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_oe     (data_oe),
      .ctrl_word   (ctrl_word),
      .cnt_load    (cnt_load),
      .cnt_value   (cnt_value),
      .cnt_current (cnt_current),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ends on the negedge where WR is raised; the commit happens on the next posedge.
   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; addr = a; data_in = d; wr_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      wr_n = 1'b1;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic oe);
      @(negedge clk);
      cs_n = 1'b0; addr = a; rd_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      d  = data_out;
      oe = data_oe;
      rd_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      addr = 2'd0; data_in = 8'h00; cnt_current = '0;

      // reset values
      @(negedge clk);
      chk("rst_ctrl_word", 48'(ctrl_word), 48'h0);
      chk("rst_cnt_load",  48'(cnt_load),  48'h0);
      chk("rst_cnt_value", 48'(cnt_value), 48'h0);
      chk("rst_data_out",  48'(data_out),  48'h0);
      chk("rst_data_oe",   48'(data_oe),   48'h0);
      chk("rst_bus_err",   48'(bus_err),   48'h0);
      rst_n = 1'b1;

      // counter 0, LSB only, mode 1
      bus_write(2'd3, 8'h12); idle(2);
      chk("cw0_lsb", 48'(ctrl_word[5:0]), 48'h12);
      bus_write(2'd0, 8'h34);
      @(negedge clk);
      chk("lsb_load",  48'(cnt_load),  48'h1);
      chk("lsb_value", 48'(cnt_value), 48'h0034);
      @(negedge clk);
      chk("lsb_load_1cyc", 48'(cnt_load), 48'h0);

      // counter 1, LSB then MSB, mode 2
      bus_write(2'd3, 8'h74); idle(2);
      chk("cw1_lm", 48'(ctrl_word[11:6]), 48'h34);
      bus_write(2'd1, 8'hCD);
      @(negedge clk); chk("lm_first_noload_a", 48'(cnt_load), 48'h0);
      @(negedge clk); chk("lm_first_noload_b", 48'(cnt_load), 48'h0);
      bus_write(2'd1, 8'hAB);
      @(negedge clk);
      chk("lm_load",  48'(cnt_load),  48'h2);
      chk("lm_value", 48'(cnt_value), 48'hABCD);
      @(negedge clk); chk("lm_load_1cyc", 48'(cnt_load), 48'h0);

      // counter 2, MSB only
      bus_write(2'd3, 8'hA4); idle(2);
      chk("cw2_msb", 48'(ctrl_word[17:12]), 48'h24);
      bus_write(2'd2, 8'h9C);
      @(negedge clk);
      chk("msb_load",  48'(cnt_load),  48'h4);
      chk("msb_value", 48'(cnt_value), 48'h9C00);

      // latched LM readback on counter 0
      bus_write(2'd3, 8'h30); idle(2);
      chk("cw0_lm", 48'(ctrl_word[5:0]), 48'h30);
      cnt_current[15:0] = 16'h1234;
      bus_write(2'd3, 8'h00); idle(2);
      cnt_current[15:0] = 16'h1111;
      bus_read(2'd0, rb, roe);
      chk("latch_rd_oe",  48'(roe), 48'h1);
      chk("latch_rd_lsb", 48'(rb),  48'h34);
      bus_read(2'd0, rb, roe);
      chk("latch_rd_msb", 48'(rb),  48'h12);
      bus_read(2'd0, rb, roe);
      chk("live_rd_lsb",  48'(rb),  48'h11);
      bus_read(2'd0, rb, roe);
      chk("live_rd_msb",  48'(rb),  48'h11);

      // second latch while full keeps first snapshot
      cnt_current[15:0] = 16'h5678;
      bus_write(2'd3, 8'h00); idle(2);
      cnt_current[15:0] = 16'h9ABC;
      bus_write(2'd3, 8'h00); idle(2);
      bus_read(2'd0, rb, roe);
      chk("dbl_latch_lsb", 48'(rb), 48'h78);
      bus_read(2'd0, rb, roe);
      chk("dbl_latch_msb", 48'(rb), 48'h56);
      bus_read(2'd0, rb, roe);
      chk("after_latch_live", 48'(rb), 48'hBC);
      bus_read(2'd0, rb, roe);

      // control-word address read and chip-select gating
      bus_read(2'd3, rb, roe);
      chk("cw_rd_oe",   48'(roe), 48'h1);
      chk("cw_rd_data", 48'(rb),  48'hFF);
      @(negedge clk);
      chk("oe_release", 48'(data_oe), 48'h0);
      cs_n = 1'b1; rd_n = 1'b0; addr = 2'd0;
      idle(2);
      chk("cs_high_oe", 48'(data_oe), 48'h0);
      rd_n = 1'b1;
      idle(1);

      // rewriting the control word resets a half-written LM pair
      bus_write(2'd0, 8'h55); idle(2);
      bus_write(2'd3, 8'h30); idle(2);
      bus_write(2'd0, 8'h66);
      @(negedge clk); chk("ptr_reset_noload_a", 48'(cnt_load), 48'h0);
      @(negedge clk); chk("ptr_reset_noload_b", 48'(cnt_load), 48'h0);
      bus_write(2'd0, 8'h77);
      @(negedge clk);
      chk("ptr_reset_load",  48'(cnt_load),  48'h1);
      chk("ptr_reset_value", 48'(cnt_value), 48'h7766);

      // illegal mode
      chk("no_err_yet", 48'(bus_err), 48'h0);
      bus_write(2'd3, 8'h0A); idle(2);
      chk("bad_mode_cw",  48'(ctrl_word[5:0]), 48'h30);
      chk("bad_mode_err", 48'(bus_err), 48'h1);

      // RD and WR low together
      do_reset();
      bus_write(2'd3, 8'h12); idle(2);
      chk("clash_pre_err", 48'(bus_err), 48'h0);
      @(negedge clk);
      cs_n = 1'b0; addr = 2'd0; data_in = 8'h99; wr_n = 1'b0; rd_n = 1'b0;
      idle(2);
      chk("clash_oe", 48'(data_oe), 48'h0);
      wr_n = 1'b1; rd_n = 1'b1;
      @(negedge clk); chk("clash_noload_a", 48'(cnt_load), 48'h0);
      @(negedge clk); chk("clash_noload_b", 48'(cnt_load), 48'h0);
      chk("clash_err", 48'(bus_err), 48'h1);

      // reset in the middle of an LM write
      do_reset();
      bus_write(2'd3, 8'h30); idle(2);
      bus_write(2'd0, 8'h55); idle(2);
      @(negedge clk);
      cs_n = 1'b0; addr = 2'd0; data_in = 8'hAA; wr_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midwr_rst_ctrl", 48'(ctrl_word), 48'h0);
      chk("midwr_rst_load", 48'(cnt_load),  48'h0);
      chk("midwr_rst_err",  48'(bus_err),   48'h0);
      @(negedge clk);
      wr_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midwr_noload", 48'(cnt_load), 48'h0);
      end

      // reset in the middle of a latched read
      bus_write(2'd3, 8'h30); idle(2);
      cnt_current[15:0] = 16'h4321;
      bus_write(2'd3, 8'h00); idle(2);
      cnt_current[15:0] = 16'h0000;
      bus_read(2'd0, rb, roe);
      chk("midrd_lsb", 48'(rb), 48'h21);
      @(negedge clk);
      cs_n = 1'b0; addr = 2'd0; rd_n = 1'b0;
      idle(2);
      chk("midrd_oe",  48'(data_oe),  48'h1);
      chk("midrd_msb", 48'(data_out), 48'h43);
      rst_n = 1'b0;
      #1;
      chk("midrd_rst_oe",   48'(data_oe),  48'h0);
      chk("midrd_rst_data", 48'(data_out), 48'h0);
      @(negedge clk);
      rd_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      bus_write(2'd3, 8'h30); idle(2);
      bus_read(2'd0, rb, roe);
      chk("midrd_latch_gone", 48'(rb), 48'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
